reaction_timer: RTL and testbench

REACTION_TIMER -- requirements
Module: reaction_timer

---
 rtl/reaction_timer_pkg.sv | 37 +++
 rtl/reaction_timer_bcd_counter4.sv | 21 ++
 rtl/reaction_timer.sv | 125 ++++++++++++
 tb/tb_reaction_timer.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the drag-strip reaction timer.
// Holds the FSM state enum, BCD limits and a BCD increment helper.
package reaction_timer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_TIMING,
    S_DONE,
    S_FOUL
  } state_t;

  localparam logic [15:0] BCD_MAX  = 16'h9999;
  localparam logic [15:0] BCD_ZERO = 16'h0000;

  // Add one to a 4-digit BCD value; digits roll 9->0 with carry.
  function automatic logic [15:0] bcd_inc(
    input logic [15:0] v
  );
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reaction_timer_bcd_counter4.sv
// Four-digit BCD up-counter with clear and saturation at 9999.
// Ports: clk, rst (sync high), clr, inc, value[15:0].
module bcd_counter4
  import reaction_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= BCD_ZERO;
    end else if (inc && (value != BCD_MAX)) begin
      value <= bcd_inc(value);
    end
  end

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: counts ms from green to the car leaving the beam.
// Ports: Clock, Rst, G, SB in; RT_BCD, Timing, Done, Foul, BEST_BCD out.
// Macro REACTION_TIMER_BEST_EN enables the best-time register.
module reaction_timer
  import reaction_timer_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1000
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        G,
  input  logic        SB,
  output logic [15:0] RT_BCD,
  output logic        Timing,
  output logic        Done,
  output logic        Foul,
  output logic [15:0] BEST_BCD
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  state_t state;
  state_t nxt;

  logic          sb_meta;
  logic          sb_sync;
  logic [PW-1:0] presc;
  logic          tick;
  logic          go;
  logic          inc;
  logic          stop;

  always_ff @(posedge Clock) begin
    if (Rst) begin
      sb_meta <= 1'b0;
      sb_sync <= 1'b0;
    end else begin
      sb_meta <= SB;
      sb_sync <= sb_meta;
    end
  end

  assign tick = (presc == PMAX);
  // Early-leave wins over green in the same ARMED cycle.
  assign go   = (state == S_ARMED) && sb_sync && G;
  // A tick coinciding with the beam clearing is not counted.
  assign inc  = (state == S_TIMING) && sb_sync && tick;
  assign stop = (state == S_TIMING) && !sb_sync;

  // Restarting here puts the first tick DIV cycles after green.
  always_ff @(posedge Clock) begin
    if (Rst || go) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (sb_sync && !G) nxt = S_ARMED;
      end
      S_ARMED: begin
        if (!sb_sync)  nxt = S_FOUL;
        else if (G)    nxt = S_TIMING;
      end
      S_TIMING: begin
        if (!sb_sync) nxt = S_DONE;
      end
      S_DONE, S_FOUL: begin
        if (!sb_sync && !G) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      state  <= S_IDLE;
      Timing <= 1'b0;
      Done   <= 1'b0;
      Foul   <= 1'b0;
    end else begin
      state  <= nxt;
      Timing <= (nxt == S_TIMING);
      Done   <= (nxt == S_DONE);
      Foul   <= (nxt == S_FOUL);
    end
  end

  bcd_counter4 u_cnt (
    .clk   (Clock),
    .rst   (Rst),
    .clr   (go),
    .inc   (inc),
    .value (RT_BCD)
  );

`ifdef REACTION_TIMER_BEST_EN
  logic [15:0] best_q;

  // Count is frozen on the stop cycle, so RT_BCD is final here.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      best_q <= BCD_MAX;
    end else if (stop && (RT_BCD < best_q)) begin
      best_q <= RT_BCD;
    end
  end

  assign BEST_BCD = best_q;
`else
  logic unused_stop;
  assign unused_stop = stop;
  assign BEST_BCD    = BCD_MAX;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer.
// Main DUT at 10 cycles/tick; second DUT at 2 cycles/tick.
module tb_reaction_timer;

  logic Clock = 1'b0;
  logic Rst;
  logic G;
  logic SB;
  logic [15:0] RT_BCD;
  logic Timing;
  logic Done;
  logic Foul;
  logic [15:0] BEST_BCD;

  logic G2;
  logic SB2;
  logic [15:0] RT2;
  logic Timing2;
  logic Done2;
  logic Foul2;
  logic [15:0] BEST2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clock = ~Clock;

  reaction_timer #(
    .CLK_HZ  (1000),
    .TICK_HZ (100)
  ) dut (
    .Clock    (Clock),
    .Rst      (Rst),
    .G        (G),
    .SB       (SB),
    .RT_BCD   (RT_BCD),
    .Timing   (Timing),
    .Done     (Done),
    .Foul     (Foul),
    .BEST_BCD (BEST_BCD)
  );

  reaction_timer #(
    .CLK_HZ  (200),
    .TICK_HZ (100)
  ) dut2 (
    .Clock    (Clock),
    .Rst      (Rst),
    .G        (G2),
    .SB       (SB2),
    .RT_BCD   (RT2),
    .Timing   (Timing2),
    .Done     (Done2),
    .Foul     (Foul2),
    .BEST_BCD (BEST2)
  );

  task automatic arm();
    @(negedge Clock);
    SB = 1'b1;
    G  = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
  endtask

  // Green, k edges later drop the beam; wait for Done.
  task automatic run(input int k, output bit ok);
    arm();
    G = 1'b1;
    @(posedge Clock);
    repeat (k) @(posedge Clock);
    @(negedge Clock);
    SB = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (Done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic back_to_idle();
    @(negedge Clock);
    G  = 1'b0;
    SB = 1'b0;
    repeat (4) @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic pulse_rst();
    @(negedge Clock);
    Rst = 1'b1;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    G   = 1'b0;
    SB  = 1'b0;
    G2  = 1'b0;
    SB2 = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    n_cmp++;
    if (RT_BCD !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_rt got %h want 0000", RT_BCD);
    end
    n_cmp++;
    if (BEST_BCD !== 16'h9999) begin
      n_bad++;
      $display("FAIL reset_best got %h want 9999", BEST_BCD);
    end
    n_cmp++;
    if ({Timing, Done, Foul} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 000",
               {Timing, Done, Foul});
    end
    Rst = 1'b0;
  endtask

  task automatic test_idle_hold();
    @(negedge Clock);
    G  = 1'b1;
    SB = 1'b1;
    repeat (6) @(posedge Clock);
    @(negedge Clock);
    n_cmp++;
    if ({Timing, Done, Foul} !== 3'b000) begin
      n_bad++;
      $display("FAIL idle_hold got %b want 000",
               {Timing, Done, Foul});
    end
    back_to_idle();
  endtask

  task automatic test_normal();
    bit ok;
    run(237, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL normal_done_timeout got 0 want 1");
    end
    n_cmp++;
    if (RT_BCD !== 16'h0023) begin
      n_bad++;
      $display("FAIL normal_rt got %h want 0023", RT_BCD);
    end
    n_cmp++;
    if ({Timing, Done, Foul} !== 3'b010) begin
      n_bad++;
      $display("FAIL normal_flags got %b want 010",
               {Timing, Done, Foul});
    end
    back_to_idle();
    n_cmp++;
    if ({Done, RT_BCD} !== {1'b0, 16'h0023}) begin
      n_bad++;
      $display("FAIL normal_hold got %b/%h want 0/0023",
               Done, RT_BCD);
    end
  endtask

  task automatic test_foul();
    arm();
    SB = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    n_cmp++;
    if ({Timing, Done, Foul} !== 3'b001) begin
      n_bad++;
      $display("FAIL foul_flags got %b want 001",
               {Timing, Done, Foul});
    end
    n_cmp++;
    if (RT_BCD !== 16'h0023) begin
      n_bad++;
      $display("FAIL foul_rt got %h want 0023", RT_BCD);
    end
    back_to_idle();
    n_cmp++;
    if (Foul !== 1'b0) begin
      n_bad++;
      $display("FAIL foul_exit got %b want 0", Foul);
    end
  endtask

  task automatic test_foul_same_cycle();
    arm();
    SB = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    G = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    n_cmp++;
    if ({Timing, Done, Foul} !== 3'b001) begin
      n_bad++;
      $display("FAIL foul_same got %b want 001",
               {Timing, Done, Foul});
    end
    back_to_idle();
  endtask

  task automatic test_carry();
    bit ok;
    run(97, ok);
    n_cmp++;
    if (!ok || RT_BCD !== 16'h0009) begin
      n_bad++;
      $display("FAIL carry_edge got %h ok=%0d want 0009",
               RT_BCD, ok);
    end
    back_to_idle();
    run(1000, ok);
    n_cmp++;
    if (!ok || RT_BCD !== 16'h0100) begin
      n_bad++;
      $display("FAIL carry_100 got %h ok=%0d want 0100",
               RT_BCD, ok);
    end
    back_to_idle();
  endtask

  task automatic test_best();
    bit ok;
    logic [15:0] want;
    pulse_rst();
    run(453, ok);
    back_to_idle();
    run(313, ok);
    back_to_idle();
    run(523, ok);
    n_cmp++;
    if (!ok || RT_BCD !== 16'h0052) begin
      n_bad++;
      $display("FAIL best_last_rt got %h want 0052", RT_BCD);
    end
    back_to_idle();
`ifdef REACTION_TIMER_BEST_EN
    want = 16'h0031;
`else
    want = 16'h9999;
`endif
    n_cmp++;
    if (BEST_BCD !== want) begin
      n_bad++;
      $display("FAIL best_val got %h want %h", BEST_BCD, want);
    end
    pulse_rst();
    n_cmp++;
    if (BEST_BCD !== 16'h9999) begin
      n_bad++;
      $display("FAIL best_rst got %h want 9999", BEST_BCD);
    end
  endtask

  task automatic test_midrun_reset();
    arm();
    G = 1'b1;
    @(posedge Clock);
    repeat (175) @(posedge Clock);
    @(negedge Clock);
    n_cmp++;
    if (RT_BCD !== 16'h0017 || Timing !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_pre got %h/%b want 0017/1",
               RT_BCD, Timing);
    end
    Rst = 1'b1;
    @(posedge Clock);
    #1;
    n_cmp++;
    if ({Timing, Done, Foul, RT_BCD} !==
        {3'b000, 16'h0000}) begin
      n_bad++;
      $display("FAIL mid_rst got %b/%h want 000/0000",
               {Timing, Done, Foul}, RT_BCD);
    end
    @(negedge Clock);
    Rst = 1'b0;
    G   = 1'b0;
    SB  = 1'b0;
    repeat (4) @(posedge Clock);
  endtask

  task automatic test_saturation();
    bit ok;
    @(negedge Clock);
    SB2 = 1'b1;
    G2  = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    G2 = 1'b1;
    @(posedge Clock);
    repeat (1998) @(posedge Clock);
    @(negedge Clock);
    n_cmp++;
    if (RT2 !== 16'h0999) begin
      n_bad++;
      $display("FAIL sat_0999 got %h want 0999", RT2);
    end
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    n_cmp++;
    if (RT2 !== 16'h1000) begin
      n_bad++;
      $display("FAIL sat_1000 got %h want 1000", RT2);
    end
    repeat (18500) @(posedge Clock);
    @(negedge Clock);
    n_cmp++;
    if (RT2 !== 16'h9999 || Timing2 !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_hold got %h/%b want 9999/1",
               RT2, Timing2);
    end
    SB2 = 1'b0;
    ok  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (Done2) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok || RT2 !== 16'h9999 || Foul2 !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_done got %h ok=%0d want 9999",
               RT2, ok);
    end
    n_cmp++;
    if (BEST2 === 16'hxxxx) begin
      n_bad++;
      $display("FAIL sat_best got %h want known", BEST2);
    end
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_normal();
    test_foul();
    test_foul_same_cycle();
    test_carry();
    test_best();
    test_midrun_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
